// File: rtl/dmem_pkg.sv
// Shared types and constants for the multi-cycle data-memory responder.
// State encoding, latency counter width and the index-width helper live here.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int CNT_W = 4;

  // Ceiling log2, used to size the word index from the array depth.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// CPU data-access handshake between the MEM stage (master) and the responder (slave).
// Carries the request, the one-cycle response and the pipeline stall.
interface dmem_responder_if;

  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        stall;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, stall
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err, stall
  );

endinterface

// File: rtl/dmem_array.sv
// Single-port word array: synchronous write, registered read.
// The read register loads zero whenever no read is requested, so it doubles as the response data register.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  localparam int IDX_W = clog2(DEPTH_WORDS)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_we,
  input  logic             i_re,
  input  logic [IDX_W-1:0] i_index,
  input  logic [31:0]      i_wdata,
  output logic [31:0]      o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;

  // NOTE: the storage array is deliberately left out of reset so it maps onto RAM; only the read register is reset.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_index] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_index];
    end else begin
      r_rdata <= '0;
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM stage: accepts one word request, stalls the
// pipeline for LATENCY cycles, then pulses a registered response for exactly one cycle.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input logic              i_clk,
  input logic              i_rst,
  dmem_responder_if.slave  bus
);

  localparam int IDX_W = clog2(DEPTH_WORDS);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_we;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic             r_resp_valid;
  logic             r_resp_err;

  logic             w_accept;
  logic             w_to_resp;
  logic             w_acc_we;
  logic [31:0]      w_acc_addr;
  logic [31:0]      w_acc_wdata;
  logic             w_err;
  logic             w_mem_we;
  logic             w_mem_re;
  logic [IDX_W-1:0] w_index;
  logic [31:0]      w_rdata;

  assign w_accept  = (r_state == IDLE) && bus.req_valid;
  assign w_to_resp = (w_accept && (LATENCY == 1)) ||
                     ((r_state == BUSY) && (r_cnt == CNT_W'(1)));

  // With LATENCY=1 the access completes on the accepting edge, before the latches hold it.
  assign w_acc_we    = (r_state == IDLE) ? bus.req_we    : r_we;
  assign w_acc_addr  = (r_state == IDLE) ? bus.req_addr  : r_addr;
  assign w_acc_wdata = (r_state == IDLE) ? bus.req_wdata : r_wdata;

  assign w_err = (w_acc_addr[1:0] != 2'b00) ||
                 ({2'b00, w_acc_addr[31:2]} >= 32'(DEPTH_WORDS));

  assign w_index  = w_acc_addr[2 +: IDX_W];
  assign w_mem_we = w_to_resp &&  w_acc_we && !w_err;
  assign w_mem_re = w_to_resp && !w_acc_we && !w_err;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_we    (w_mem_we),
    .i_re    (w_mem_re),
    .i_index (w_index),
    .i_wdata (w_acc_wdata),
    .o_rdata (w_rdata)
  );

  // NOTE: every register here is written with <= so all updates see pre-edge values, whatever the statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
    end else begin
      r_resp_valid <= w_to_resp;
      r_resp_err   <= w_to_resp && w_err;
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_we    <= bus.req_we;
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wdata;
            if (LATENCY == 1) begin
              r_state <= RESP;
            end else begin
              r_state <= BUSY;
              r_cnt   <= CNT_W'(LATENCY - 1);
            end
          end
        end
        BUSY: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state <= RESP;
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = (r_state == IDLE);
  assign bus.stall      = w_accept || (r_state == BUSY);
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_err   = r_resp_err;
  assign bus.resp_rdata = w_rdata;

endmodule
